// File: rtl/linear_layer_srl_fifo_pkg.sv
// Shared constants and width helper for the SRL FIFO.
// Imported by the storage array and the FIFO control top.
package linear_layer_srl_fifo_pkg;

   // Active level of the HLS request and clock-enable qualifiers
   localparam logic REQ_ACTIVE = 1'b1;
   localparam logic CE_ACTIVE  = 1'b1;

   // Bits needed to count 0..depth inclusive
   function automatic int FIFO_CNT_W(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/linear_layer_srl_fifo_shiftreg.sv
// SRL storage: shift-in at entry 0, random-access read.
// Holds data only; occupancy lives in the FIFO control.
module linear_layer_srl_fifo_shiftreg
   import linear_layer_srl_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] srl_q [DEPTH];
   logic [DATA_WIDTH-1:0] srl_d [DEPTH];

   // Shift every entry up by one and insert the new word at entry 0
   always_comb begin
      srl_d = srl_q;
      if (we) begin
         srl_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            srl_d[i] = srl_q[i-1];
         end
      end
   end

   // Storage array, deliberately not reset
   always_ff @(posedge clk) begin
      srl_q <= srl_d;
   end

   // Read mux; addresses beyond DEPTH-1 return zero
   always_comb begin
      dout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == ADDR_WIDTH'(i)) begin
            dout = srl_q[i];
         end
      end
   end

endmodule

// File: rtl/linear_layer_srl_fifo.sv
// SRL FIFO with a registered head stage between PE tasks.
// Capacity is DEPTH words in the SRL plus one in the head.
module linear_layer_srl_fifo
   import linear_layer_srl_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH+1:0] if_num_data_valid
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   generate
      if (DEPTH < 1 || (2 ** ADDR_WIDTH) < DEPTH ||
          FIFO_CNT_W(DEPTH) > CW) begin : g_bad_params
         $error("linear_layer_srl_fifo: bad DEPTH/ADDR_WIDTH");
      end
   endgenerate

   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] srl_dout;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  full_n;
   logic                  push, pop, load;

   // Qualify requests and pick the oldest SRL entry
   always_comb begin
      full_n  = (cnt_q != CNT_DEPTH);
      push    = (if_write == REQ_ACTIVE) &
                (if_write_ce == CE_ACTIVE) & full_n;
      pop     = (if_read == REQ_ACTIVE) &
                (if_read_ce == CE_ACTIVE) & out_valid_q;
      load    = (cnt_q != '0) & (~out_valid_q | pop);
      rd_addr = cnt_q[ADDR_WIDTH-1:0] - ADDR_ONE;
   end

   // Occupancy and head-register next state
   always_comb begin
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      if (push & ~load) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (load & ~push) begin
         cnt_d = cnt_q - CNT_ONE;
      end
      if (load) begin
         out_valid_d = 1'b1;
         dout_d      = srl_dout;
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
      end else begin
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
      end
   end

   linear_layer_srl_fifo_shiftreg #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_srl (
      .clk  (clk),
      .we   (push & ~reset),
      .addr (rd_addr),
      .din  (if_din),
      .dout (srl_dout)
   );

   assign if_full_n         = full_n;
   assign if_empty_n        = out_valid_q;
   assign if_dout           = dout_q;
   assign if_num_data_valid = {1'b0, cnt_q} + {{CW{1'b0}}, out_valid_q};

endmodule

// File: tb/tb_linear_layer_srl_fifo.sv
// Bench: two FIFO sizes driven in lockstep, checked against
// a queue model every cycle plus directed literal checks.
module tb_linear_layer_srl_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr, wce, rd, rce;
   logic [7:0] din;

   logic       full_n2, empty_n2, full_n4, empty_n4;
   logic [7:0] dout2, dout4;
   logic [2:0] nvd2;
   logic [3:0] nvd4;

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 0;

   always #5 clk = ~clk;

   linear_layer_srl_fifo #(
      .DATA_WIDTH (8), .ADDR_WIDTH (1), .DEPTH (2)
   ) u_d2 (
      .clk (clk), .reset (reset),
      .if_write_ce (wce), .if_write (wr), .if_din (din),
      .if_full_n (full_n2),
      .if_read_ce (rce), .if_read (rd),
      .if_dout (dout2), .if_empty_n (empty_n2),
      .if_num_data_valid (nvd2)
   );

   linear_layer_srl_fifo #(
      .DATA_WIDTH (8), .ADDR_WIDTH (2), .DEPTH (4)
   ) u_d4 (
      .clk (clk), .reset (reset),
      .if_write_ce (wce), .if_write (wr), .if_din (din),
      .if_full_n (full_n4),
      .if_read_ce (rce), .if_read (rd),
      .if_dout (dout4), .if_empty_n (empty_n4),
      .if_num_data_valid (nvd4)
   );

   // Model: SRL word queue, head register, and an order scoreboard
   int         dep [2] = '{2, 4};
   logic [7:0] mq [2][$];
   logic [7:0] sb [2][$];
   bit         hv [2];
   logic [7:0] hd [2];
   int         pops [2] = '{0, 0};

   logic       fn [2], en [2];
   logic [7:0] dq [2];
   logic [3:0] nv [2];

   always_comb begin
      fn[0] = full_n2;  fn[1] = full_n4;
      en[0] = empty_n2; en[1] = empty_n4;
      dq[0] = dout2;    dq[1] = dout4;
      nv[0] = {1'b0, nvd2};
      nv[1] = nvd4;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic mstep(input int i);
      int c;
      bit push, pop, load;
      if (reset) begin
         mq[i].delete();
         sb[i].delete();
         hv[i] = 0;
         hd[i] = '0;
      end else begin
         c    = mq[i].size();
         push = wr && wce && (c != dep[i]);
         pop  = rd && rce && hv[i];
         load = (c != 0) && (!hv[i] || pop);
         if (load) begin
            hd[i] = mq[i].pop_front();
            hv[i] = 1;
         end else if (pop) begin
            hv[i] = 0;
         end
         if (push) begin
            mq[i].push_back(din);
            sb[i].push_back(din);
         end
      end
   endtask

   always @(posedge clk) begin
      mstep(0);
      mstep(1);
      if (reset) started = 1;
   end

   // Compare process, away from the active edge
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("full_n[%0d]", i), 32'(fn[i]),
                32'(mq[i].size() != dep[i]));
            chk($sformatf("empty_n[%0d]", i), 32'(en[i]), 32'(hv[i]));
            chk($sformatf("count[%0d]", i), 32'(nv[i]),
                32'(mq[i].size() + int'(hv[i])));
            chk($sformatf("dout[%0d]", i), 32'(dq[i]), 32'(hd[i]));
            if (!reset && en[i] && rd && rce) begin
               if (sb[i].size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL order[%0d]: pop with empty scoreboard", i);
               end else begin
                  chk($sformatf("order[%0d]", i), 32'(dq[i]),
                      32'(sb[i].pop_front()));
               end
               pops[i]++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic w, input logic r, input logic [7:0] d);
      wr = w; rd = r; din = d; wce = 1'b1; rce = 1'b1;
   endtask

   int p0, p1, rp;

   initial begin
      reset = 1'b1;
      drv(0, 0, 8'h00);
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_full_n", 32'(full_n2), 32'd1);
      chk("rst_empty_n", 32'(empty_n2), 32'd0);
      chk("rst_dout", 32'(dout2), 32'd0);
      chk("rst_count", 32'(nvd2), 32'd0);

      // Fill the depth-2 FIFO, then a write while full
      drv(1, 0, 8'h0A); tick();
      drv(1, 0, 8'h0B); tick();
      drv(1, 0, 8'h0C); tick();
      chk("fill_full_n", 32'(full_n2), 32'd0);
      chk("fill_count", 32'(nvd2), 32'd3);
      chk("fill_head", 32'(dout2), 32'h0A);
      drv(1, 0, 8'h0D); tick();
      chk("wfull_count", 32'(nvd2), 32'd3);
      chk("wfull_full_n", 32'(full_n2), 32'd0);
      chk("d4_count4", 32'(nvd4), 32'd4);
      drv(0, 1, 8'h00); tick();
      chk("pop1_head", 32'(dout2), 32'h0B);
      chk("pop1_full_n", 32'(full_n2), 32'd1);
      tick();
      chk("pop2_head", 32'(dout2), 32'h0C);
      tick();
      chk("pop3_empty_n", 32'(empty_n2), 32'd0);
      chk("pop3_dout_hold", 32'(dout2), 32'h0C);
      chk("d4_last", 32'(dout4), 32'h0D);
      tick();
      chk("d4_empty", 32'(empty_n4), 32'd0);

      // Write-to-read latency into an empty FIFO
      drv(1, 0, 8'h5A); tick();
      drv(0, 0, 8'h00);
      chk("lat_n1_empty_n", 32'(empty_n2), 32'd0);
      tick();
      chk("lat_n2_empty_n", 32'(empty_n2), 32'd1);
      chk("lat_count", 32'(nvd2), 32'd1);
      chk("lat_dout", 32'(dout2), 32'h5A);
      drv(0, 1, 8'h00); tick();
      drv(0, 0, 8'h00);

      // Reset with 3 words held, with a push/pop in the same cycle
      drv(1, 0, 8'h01); tick();
      drv(1, 0, 8'h02); tick();
      drv(1, 0, 8'h03); tick();
      drv(1, 1, 8'h04);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drv(0, 0, 8'h00);
      chk("mrst_full_n", 32'(full_n2), 32'd1);
      chk("mrst_empty_n", 32'(empty_n2), 32'd0);
      chk("mrst_count", 32'(nvd2), 32'd0);
      chk("mrst_dout", 32'(dout2), 32'd0);
      chk("mrst_count4", 32'(nvd4), 32'd0);

      // Full FIFO with simultaneous push and pop
      drv(1, 0, 8'h21); tick();
      drv(1, 0, 8'h22); tick();
      drv(1, 0, 8'h23); tick();
      chk("fp_full_n_pre", 32'(full_n2), 32'd0);
      drv(1, 1, 8'h24); tick();
      chk("fp_count", 32'(nvd2), 32'd2);
      chk("fp_full_n", 32'(full_n2), 32'd1);
      chk("fp_head", 32'(dout2), 32'h22);
      chk("fp_count4", 32'(nvd4), 32'd3);
      drv(0, 1, 8'h00);
      repeat (5) tick();

      // Streaming: 100 words with the reader always ready
      p0 = pops[0];
      p1 = pops[1];
      for (int i = 0; i < 100; i++) begin
         drv(1, 1, 8'(i));
         tick();
         if (i == 50) begin
            chk("stream_count", 32'(nvd2), 32'd2);
            chk("stream_count4", 32'(nvd4), 32'd2);
         end
      end
      drv(0, 1, 8'h00);
      repeat (3) tick();
      chk("stream_pops", 32'(pops[0] - p0), 32'd100);
      chk("stream_pops4", 32'(pops[1] - p1), 32'd100);
      chk("stream_last", 32'(dout2), 32'd99);

      // Random handshake and clock-enable traffic
      rp = 50;
      for (int n = 0; n < 10000; n++) begin
         if (n % 500 == 0) begin
            case ($urandom_range(0, 2))
               0: rp = 20;
               1: rp = 50;
               default: rp = 85;
            endcase
         end
         wr    = 1'($urandom_range(0, 1));
         wce   = ($urandom_range(0, 3) != 0);
         rd    = ($urandom_range(0, 99) < rp);
         rce   = ($urandom_range(0, 3) != 0);
         din   = 8'($urandom);
         reset = ($urandom_range(0, 1999) == 0);
         tick();
      end
      reset = 1'b0;
      drv(0, 1, 8'h00);
      repeat (8) tick();
      chk("final_empty_n", 32'(empty_n4), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
